// File: rtl/qr_ori_loader.sv
// Purpose: buffers one DEPTH-word matrix from a valid/ready host stream, then serves it to QR_CORDIC's ori read port.
// Latency: read data one cycle after ori_rd; core leaves reset the cycle after the last word is accepted.
// Backpressure: in_ready is high only while loading; host words are neither accepted nor acknowledged in RUN/FIN.
module qr_ori_loader #(
  parameter int LENGTH = 13,
  parameter int DEPTH  = 32,
  parameter int AW     = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [LENGTH-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              core_rst_n,
  input  logic              ori_rd,
  input  logic [AW-1:0]     ori_addr,
  output logic [LENGTH-1:0] ori_di,
  input  logic              done,
  input  logic              restart,
  output logic              busy,
  output logic              finished,
  output logic              load_err,
  output logic [15:0]       run_cycles
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t            state;
  logic [AW-1:0]     wr_ptr;
  logic [LENGTH-1:0] mem [DEPTH];
  logic              accept;
  logic              at_last;

  // Ready depends on state alone so the host never sees a valid->ready loop.
  assign in_ready = (state == LOAD);
  assign accept   = in_valid & in_ready;
  assign at_last  = (wr_ptr == LAST_ADDR);

  // Frame sequencing, run-cycle counting and registered state-decoded outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= LOAD;
      wr_ptr     <= '0;
      core_rst_n <= 1'b0;
      busy       <= 1'b0;
      finished   <= 1'b0;
      load_err   <= 1'b0;
      run_cycles <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            if (at_last && in_last) begin
              // Complete frame: release the core on the very next cycle.
              wr_ptr     <= '0;
              state      <= RUN;
              core_rst_n <= 1'b1;
              busy       <= 1'b1;
            end else if (at_last || in_last) begin
              // Short or overlong frame: discard and restart from address 0.
              wr_ptr   <= '0;
              load_err <= 1'b1;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end
        RUN: begin
          // The cycle that samples done is still a run cycle.
          if (run_cycles != 16'hFFFF) begin
            run_cycles <= run_cycles + 16'd1;
          end
          if (done) begin
            state    <= FIN;
            finished <= 1'b1;
          end
        end
        FIN: begin
          // Core stays out of reset so its result RAM and done survive until restart.
          if (restart) begin
            state      <= LOAD;
            run_cycles <= '0;
            load_err   <= 1'b0;
            core_rst_n <= 1'b0;
            busy       <= 1'b0;
            finished   <= 1'b0;
          end
        end
        default: begin
          state      <= LOAD;
          wr_ptr     <= '0;
          core_rst_n <= 1'b0;
          busy       <= 1'b0;
          finished   <= 1'b0;
        end
      endcase
    end
  end

  // Matrix storage; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (reset && accept) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Core read port: one-cycle latency, holds when not strobed, old data on same-address write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ori_di <= '0;
    end else if (ori_rd) begin
      ori_di <= mem[ori_addr];
    end
  end

endmodule

// File: tb/tb_qr_ori_loader.sv
// Purpose: directed-sequence bench for qr_ori_loader with random frame contents and a reference model.
// Latency: outputs are sampled 1 time unit after each rising clk edge.
// Backpressure: host stream is only driven while the loader is expected to be loading.
module tb_qr_ori_loader;

  localparam int LENGTH = 13;
  localparam int DEPTH  = 32;
  localparam int AW     = 5;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic [LENGTH-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic              core_rst_n;
  logic              ori_rd;
  logic [AW-1:0]     ori_addr;
  logic [LENGTH-1:0] ori_di;
  logic              done;
  logic              restart;
  logic              busy;
  logic              finished;
  logic              load_err;
  logic [15:0]       run_cycles;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int entry_cyc = 0;

  // Reference model: what the array should hold, and which words are known.
  logic [LENGTH-1:0] model_mem [DEPTH];
  bit                model_vld [DEPTH];
  logic [LENGTH-1:0] frame     [DEPTH];

  qr_ori_loader #(.LENGTH(LENGTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .core_rst_n (core_rst_n),
    .ori_rd     (ori_rd),
    .ori_addr   (ori_addr),
    .ori_di     (ori_di),
    .done       (done),
    .restart    (restart),
    .busy       (busy),
    .finished   (finished),
    .load_err   (load_err),
    .run_cycles (run_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected run count: edges spent in RUN since entry, saturating at 16 bits.
  function automatic logic [31:0] exp_run();
    int d;
    d = cyc - entry_cyc;
    return (d > 65535) ? 32'd65535 : 32'(d);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model_vld[i] = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) frame[i] = LENGTH'($urandom);
    frame[7] = 13'h1FFF;
  endtask

  // Streams n words from frame[]; every word also reads the address being written.
  task automatic send_frame(input int n, input int last_idx);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = frame[i];
      in_last  = (i == last_idx);
      ori_rd   = 1'b1;
      ori_addr = AW'(i);
      check("in_ready_load", in_ready, 1);
      check("core_rst_n_load", core_rst_n, 0);
      step();
      if (model_vld[i]) check("rd_during_wr_old", ori_di, model_mem[i]);
      model_mem[i] = frame[i];
      model_vld[i] = 1'b1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    ori_rd   = 1'b0;
  endtask

  task automatic sweep();
    for (int a = DEPTH - 1; a >= 0; a--) begin
      ori_rd   = 1'b1;
      ori_addr = AW'(a);
      step();
      check("sweep_rd", ori_di, model_mem[a]);
    end
    ori_rd   = 1'b0;
    ori_addr = AW'($urandom);
    repeat (3) step();
    check("rd_hold", ori_di, model_mem[0]);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_core_rst_n"}, core_rst_n, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_finished"}, finished, 0);
    check({tag, "_load_err"}, load_err, 0);
    check({tag, "_run_cycles"}, run_cycles, 0);
    check({tag, "_ori_di"}, ori_di, 0);
  endtask

  task automatic check_entered_run(input logic exp_err);
    entry_cyc = cyc;
    check("run_core_rst_n", core_rst_n, 1);
    check("run_in_ready", in_ready, 0);
    check("run_busy", busy, 1);
    check("run_finished", finished, 0);
    check("run_load_err", load_err, exp_err);
    check("run_cycles_entry", run_cycles, exp_run());
  endtask

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    ori_rd   = 1'b0;
    ori_addr = '0;
    done     = 1'b0;
    restart  = 1'b0;
    clear_model();
    step();
    step();
    check_reset("por");
    reset = 1'b1;

    // Frame of 0..31 with in_valid held high.
    for (int i = 0; i < DEPTH; i++) frame[i] = LENGTH'(i);
    send_frame(DEPTH, DEPTH - 1);
    check_entered_run(1'b0);
    sweep();

    // Host words are ignored while running.
    in_valid = 1'b1;
    in_data  = 13'h0AAA;
    in_last  = 1'b1;
    repeat (3) begin
      step();
      check("run_ignore_host", in_ready, 0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;

    // restart is ignored in RUN.
    restart = 1'b1;
    step();
    restart = 1'b0;
    check("run_restart_busy", busy, 1);
    check("run_restart_count", run_cycles, exp_run());
    ori_rd   = 1'b1;
    ori_addr = AW'(5);
    step();
    ori_rd = 1'b0;
    check("run_mem_intact", ori_di, model_mem[5]);

    // Run 100 cycles, then done.
    while (cyc - entry_cyc < 100) step();
    done = 1'b1;
    step();
    done = 1'b0;
    check("fin_finished", finished, 1);
    check("fin_run_cycles", run_cycles, 101);
    in_valid = 1'b1;
    repeat (5) step();
    in_valid = 1'b0;
    check("fin_frozen", run_cycles, 101);
    check("fin_in_ready", in_ready, 0);
    check("fin_core_rst_n", core_rst_n, 1);
    check("fin_busy", busy, 1);

    restart = 1'b1;
    step();
    restart = 1'b0;
    check("rs_core_rst_n", core_rst_n, 0);
    check("rs_in_ready", in_ready, 1);
    check("rs_run_cycles", run_cycles, 0);
    check("rs_finished", finished, 0);
    check("rs_busy", busy, 0);

    // Early in_last, then a frame missing in_last.
    fill_random();
    send_frame(11, 10);
    check("short_load_err", load_err, 1);
    check("short_in_ready", in_ready, 1);
    check("short_core_rst_n", core_rst_n, 0);
    fill_random();
    send_frame(DEPTH, -1);
    check("long_load_err", load_err, 1);
    check("long_in_ready", in_ready, 1);
    check("long_core_rst_n", core_rst_n, 0);

    // Clean frame after errors; load_err remains sticky.
    fill_random();
    send_frame(DEPTH, DEPTH - 1);
    check_entered_run(1'b1);
    sweep();
    ori_rd   = 1'b1;
    ori_addr = AW'(7);
    step();
    ori_rd = 1'b0;
    check("neg_one", 32'($signed(ori_di)), 32'hFFFF_FFFF);
    done = 1'b1;
    step();
    done = 1'b0;
    check("fin2_finished", finished, 1);
    check("fin2_run_cycles", run_cycles, exp_run());
    check("fin2_load_err", load_err, 1);
    restart = 1'b1;
    step();
    restart = 1'b0;
    check("rs2_load_err", load_err, 0);

    // Reset at word 17 of a load.
    fill_random();
    send_frame(17, -1);
    reset = 1'b0;
    step();
    check_reset("rst_load");
    reset = 1'b1;
    clear_model();
    fill_random();
    send_frame(DEPTH, DEPTH - 1);
    check_entered_run(1'b0);
    sweep();

    // Reset at cycle 50 of RUN.
    while (cyc - entry_cyc < 50) step();
    reset = 1'b0;
    step();
    check_reset("rst_run");
    reset = 1'b1;
    clear_model();
    fill_random();
    send_frame(DEPTH, DEPTH - 1);
    check_entered_run(1'b0);
    sweep();

    // Long run: the counter saturates without wrapping.
    while (cyc - entry_cyc < 65534) step();
    check("sat_before", run_cycles, 16'hFFFE);
    step();
    check("sat_reach", run_cycles, 16'hFFFF);
    step();
    check("sat_nowrap", run_cycles, 16'hFFFF);
    while (cyc - entry_cyc < 70000) step();
    check("sat_70000", run_cycles, exp_run());
    check("sat_not_fin", finished, 0);
    done = 1'b1;
    step();
    done = 1'b0;
    check("sat_finished", finished, 1);
    check("sat_final", run_cycles, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
